// File: rtl/commit_pkg.sv
// Shared types for the commit/retire controller.
//   commit_cls_e : instruction class at a scoreboard entry, as seen by commit
//   seq_state_e  : state of the fence/AMO sequencer
//   exception_t  : core exception record (cause / tval / valid)
//   is_simple    : classes that retire immediately without side effects
package commit_pkg;

    localparam int unsigned CORE_XLEN = 64;

    typedef enum logic [3:0] {
        ALU,
        LOAD,
        STORE,
        CTRL,
        MULT,
        FPU,
        FENCE,
        FENCE_I,
        SFENCE,
        AMO,
        OTHER
    } commit_cls_e;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ISSUE,
        AMO_WAIT
    } seq_state_e;

    typedef struct packed {
        logic [CORE_XLEN-1:0] cause;
        logic [CORE_XLEN-1:0] tval;
        logic                 valid;
    } exception_t;

    function automatic logic is_simple(input commit_cls_e c);
        return c inside {ALU, LOAD, CTRL, MULT, FPU};
    endfunction

endpackage

// File: rtl/commit_fence_seq.sv
// Fence / fence.i / sfence.vma / AMO sequencer for the head of the scoreboard.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no sequence; head may start one
// DRAIN    | fence waiting for the store buffer to empty
// ISSUE    | retire the fence and pulse the matching flush request
// AMO_WAIT | AMO handed to the cache; waits for amo_ack_i (not abortable)
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   head_ok_i            port 0 entry valid and without exception
//   cls_i                class of the port 0 entry
//   halt_i, flush_i      block new sequences / abort a fence in DRAIN
//   no_st_pending_i      store buffer empty
//   amo_ack_i            AMO completed in the cache
//   state_o              current state
//   ack_o                retire port 0 this cycle (ISSUE or AMO completion)
//   amo_valid_o          AMO may execute
//   flush_commit_o       flush pipeline after an AMO
//   fence_o, fence_i_o, sfence_vma_o  one-cycle flush request pulses
module commit_fence_seq
    import commit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        head_ok_i,
    input  commit_cls_e cls_i,
    input  logic        halt_i,
    input  logic        flush_i,
    input  logic        no_st_pending_i,
    input  logic        amo_ack_i,
    output seq_state_e  state_o,
    output logic        ack_o,
    output logic        amo_valid_o,
    output logic        flush_commit_o,
    output logic        fence_o,
    output logic        fence_i_o,
    output logic        sfence_vma_o
);

    seq_state_e  state_q, state_d;
    commit_cls_e kind_q;
    logic        start_fence, start_amo;

    // A sequence only starts from a clean head; a flush in the same cycle
    // means the head entry is about to be discarded anyway.
    assign start_fence = head_ok_i && !halt_i && !flush_i
                         && (cls_i inside {FENCE, FENCE_I, SFENCE});
    assign start_amo   = head_ok_i && !halt_i && !flush_i && (cls_i == AMO);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kind_q  <= ALU;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_fence) begin
                kind_q <= cls_i;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ack_o          = 1'b0;
        amo_valid_o    = 1'b0;
        flush_commit_o = 1'b0;
        fence_o        = 1'b0;
        fence_i_o      = 1'b0;
        sfence_vma_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_fence) begin
                    state_d = DRAIN;
                end else if (start_amo) begin
                    state_d = AMO_WAIT;
                end
            end
            DRAIN: begin
                if (halt_i || flush_i) begin
                    state_d = IDLE;
                end else if (no_st_pending_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Committed on entry: a concurrent flush does not cancel it.
                ack_o        = 1'b1;
                fence_o      = (kind_q == FENCE);
                fence_i_o    = (kind_q == FENCE_I);
                sfence_vma_o = (kind_q == SFENCE);
                state_d      = IDLE;
            end
            AMO_WAIT: begin
                amo_valid_o = 1'b1;
                if (amo_ack_i) begin
                    ack_o          = 1'b1;
                    flush_commit_o = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/commit_retire_ctrl.sv
// N-wide in-order commit controller between the scoreboard head and the
// architectural state. Port 0 is the oldest entry; acks form a thermometer.
//
// Optional feature: define COMMIT_RETIRE_CNT_EN to add a retired-instruction
// counter (cnt_clr_i, retired_cnt_o).
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   halt_i, single_step_i        stop retiring / retire port 0 only
//   flush_i                      abort a fence waiting in DRAIN
//   instr_valid_i/ex/cls/rd_fpr/rd/result  per-port scoreboard entry
//   instr_tid_i, commit_tid_o    trans id of port 0 (passed through)
//   commit_ack_o                 retired this cycle
//   we_gpr_o, we_fpr_o, waddr_o, wdata_o   register file write ports
//   commit_lsu_o/commit_lsu_ready_i, no_st_pending_i  store buffer handshake
//   amo_valid_o/amo_ack_i/amo_result_i      AMO handshake
//   fence_o, fence_i_o, sfence_vma_o, flush_commit_o  flush requests
//   fflags_we_o, fflags_o        accumulated FP flags of retiring FPU ops
//   exception_o                  commit exception (port 0 only)
module commit_retire_ctrl
    import commit_pkg::*;
#(
    parameter int unsigned NR_PORTS      = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
`ifdef COMMIT_RETIRE_CNT_EN
    ,
    parameter int unsigned RET_CNT_W     = 64
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
`ifdef COMMIT_RETIRE_CNT_EN
    input  logic                     cnt_clr_i,
    output logic [RET_CNT_W-1:0]     retired_cnt_o,
`endif
    input  logic                     halt_i,
    input  logic                     single_step_i,
    input  logic                     flush_i,
    input  logic [NR_PORTS-1:0]      instr_valid_i,
    input  exception_t               instr_ex_i     [NR_PORTS],
    input  commit_cls_e              instr_cls_i    [NR_PORTS],
    input  logic [NR_PORTS-1:0]      instr_rd_fpr_i,
    input  logic [4:0]               instr_rd_i     [NR_PORTS],
    input  logic [XLEN-1:0]          instr_result_i [NR_PORTS],
    input  logic [TRANS_ID_BITS-1:0] instr_tid_i,
    output logic [NR_PORTS-1:0]      commit_ack_o,
    output logic [NR_PORTS-1:0]      we_gpr_o,
    output logic [NR_PORTS-1:0]      we_fpr_o,
    output logic [4:0]               waddr_o        [NR_PORTS],
    output logic [XLEN-1:0]          wdata_o        [NR_PORTS],
    output logic                     commit_lsu_o,
    input  logic                     commit_lsu_ready_i,
    input  logic                     no_st_pending_i,
    output logic                     amo_valid_o,
    input  logic                     amo_ack_i,
    input  logic [XLEN-1:0]          amo_result_i,
    output logic                     fence_o,
    output logic                     fence_i_o,
    output logic                     sfence_vma_o,
    output logic                     flush_commit_o,
    output logic                     fflags_we_o,
    output logic [4:0]               fflags_o,
    output exception_t               exception_o,
    output logic [TRANS_ID_BITS-1:0] commit_tid_o
);

    seq_state_e          seq_state;
    logic                seq_ack;
    logic                idle;
    logic                head_ok;
    logic                amo_wb;
    logic [NR_PORTS-1:0] elig;
    logic [NR_PORTS-1:0] ack;
    logic [NR_PORTS-1:0] unused_ex;

    assign idle    = (seq_state == IDLE);
    assign head_ok = instr_valid_i[0] && !instr_ex_i[0].valid;
    // The AMO writeback coincides with the post-AMO flush request.
    assign amo_wb  = flush_commit_o;

    commit_fence_seq u_seq (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .head_ok_i       (head_ok),
        .cls_i           (instr_cls_i[0]),
        .halt_i          (halt_i),
        .flush_i         (flush_i),
        .no_st_pending_i (no_st_pending_i),
        .amo_ack_i       (amo_ack_i),
        .state_o         (seq_state),
        .ack_o           (seq_ack),
        .amo_valid_o     (amo_valid_o),
        .flush_commit_o  (flush_commit_o),
        .fence_o         (fence_o),
        .fence_i_o       (fence_i_o),
        .sfence_vma_o    (sfence_vma_o)
    );

    assign commit_lsu_o = idle && head_ok && !halt_i && (instr_cls_i[0] == STORE);

    // elig[k] is each port's own condition; the AND-prefix turns it into an
    // in-order thermometer without a combinational chain through ack itself.
    for (genvar k = 0; k < NR_PORTS; k++) begin : g_port
        if (k == 0) begin : g_head
            assign elig[0] = (idle && head_ok && !halt_i && is_simple(instr_cls_i[0]))
                             || (commit_lsu_o && commit_lsu_ready_i)
                             || seq_ack;
            assign wdata_o[0] = amo_wb ? amo_result_i : instr_result_i[0];
        end else begin : g_tail
            assign elig[k] = idle && instr_valid_i[k] && !instr_ex_i[k].valid
                             && !halt_i && !single_step_i && is_simple(instr_cls_i[k]);
            assign wdata_o[k] = instr_result_i[k];
        end
        assign ack[k]       = &elig[k:0];
        assign we_gpr_o[k]  = ack[k] && !instr_rd_fpr_i[k];
        assign we_fpr_o[k]  = ack[k] &&  instr_rd_fpr_i[k];
        assign waddr_o[k]   = instr_rd_i[k];
        assign unused_ex[k] = ^{instr_ex_i[k].cause[CORE_XLEN-1:5], instr_ex_i[k].tval};
    end

    assign commit_ack_o = ack;
    assign commit_tid_o = instr_tid_i;

    // FPU flags travel in the low cause bits of a non-excepting entry.
    always_comb begin
        fflags_o    = '0;
        fflags_we_o = 1'b0;
        for (int k = 0; k < NR_PORTS; k++) begin
            if (ack[k] && instr_cls_i[k] == FPU) begin
                fflags_o    = fflags_o | instr_ex_i[k].cause[4:0];
                fflags_we_o = 1'b1;
            end
        end
    end

    always_comb begin
        exception_o = '0;
        if (instr_valid_i[0] && !halt_i) begin
            exception_o = instr_ex_i[0];
        end
    end

`ifdef COMMIT_RETIRE_CNT_EN
    logic [RET_CNT_W-1:0] ack_cnt;

    always_comb begin
        ack_cnt = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            ack_cnt = ack_cnt + RET_CNT_W'(ack[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            retired_cnt_o <= '0;
        end else begin
            retired_cnt_o <= retired_cnt_o + ack_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_commit_retire_ctrl.sv
module tb_commit_retire_ctrl;
    import commit_pkg::*;

    localparam int NP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, halt, ss, flush, lsu_ready, nsp, amo_ack;
    logic [NP-1:0] valid, rd_fpr;
    exception_t  ex   [NP];
    commit_cls_e cls  [NP];
    logic [4:0]  rd   [NP];
    logic [63:0] res  [NP];
    logic [2:0]  tid;
    logic [63:0] amo_res;

    logic [NP-1:0] ack, we_gpr, we_fpr;
    logic [4:0]    waddr [NP];
    logic [63:0]   wdata [NP];
    logic          lsu, amo_valid, fence, fence_i, sfence, flush_commit, fflags_we;
    logic [4:0]    fflags;
    exception_t    exc;
    logic [2:0]    ctid;
`ifdef COMMIT_RETIRE_CNT_EN
    logic          cnt_clr;
    logic [63:0]   ret_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    commit_retire_ctrl #(.NR_PORTS(NP), .XLEN(64), .TRANS_ID_BITS(3)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
`ifdef COMMIT_RETIRE_CNT_EN
        .cnt_clr_i          (cnt_clr),
        .retired_cnt_o      (ret_cnt),
`endif
        .halt_i             (halt),
        .single_step_i      (ss),
        .flush_i            (flush),
        .instr_valid_i      (valid),
        .instr_ex_i         (ex),
        .instr_cls_i        (cls),
        .instr_rd_fpr_i     (rd_fpr),
        .instr_rd_i         (rd),
        .instr_result_i     (res),
        .instr_tid_i        (tid),
        .commit_ack_o       (ack),
        .we_gpr_o           (we_gpr),
        .we_fpr_o           (we_fpr),
        .waddr_o            (waddr),
        .wdata_o            (wdata),
        .commit_lsu_o       (lsu),
        .commit_lsu_ready_i (lsu_ready),
        .no_st_pending_i    (nsp),
        .amo_valid_o        (amo_valid),
        .amo_ack_i          (amo_ack),
        .amo_result_i       (amo_res),
        .fence_o            (fence),
        .fence_i_o          (fence_i),
        .sfence_vma_o       (sfence),
        .flush_commit_o     (flush_commit),
        .fflags_we_o        (fflags_we),
        .fflags_o           (fflags),
        .exception_o        (exc),
        .commit_tid_o       (ctid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        halt = 0; ss = 0; flush = 0; lsu_ready = 0; nsp = 1; amo_ack = 0;
        amo_res = '0; tid = '0; valid = '0; rd_fpr = '0;
        for (int k = 0; k < NP; k++) begin
            ex[k]  = '0;
            cls[k] = ALU;
            rd[k]  = 5'(k + 1);
            res[k] = 64'h1000 + 64'(k);
        end
    endtask

    task automatic put(input int k, input commit_cls_e c);
        valid[k] = 1'b1;
        cls[k]   = c;
    endtask

    initial begin
`ifdef COMMIT_RETIRE_CNT_EN
        cnt_clr = 0;
`endif
        clr();
        rst = 1;
        step(); step();
        #2;
        chk("rst_ack", 64'(ack), 0);
        chk("rst_amo_valid", 64'(amo_valid), 0);
        chk("rst_exc_valid", 64'(exc.valid), 0);
        chk("rst_fflags_we", 64'(fflags_we), 0);
        chk("rst_pulses", 64'({fence, fence_i, sfence, flush_commit}), 0);
        rst = 0;
        step();

`ifdef COMMIT_RETIRE_CNT_EN
        put(0, ALU); put(1, ALU);
        step(); step(); step();
        #2 chk("cnt_six", ret_cnt, 6);
        valid = 4'b0001; cnt_clr = 1;
        step();
        #2 chk("cnt_clear", ret_cnt, 0);
        cnt_clr = 0; clr();
        step();
`endif

        // Full-width ALU retire, then FPR routing.
        clr(); put(0, ALU); put(1, ALU); put(2, ALU); put(3, ALU);
        #2;
        chk("alu4_ack", 64'(ack), 4'b1111);
        chk("alu4_we_gpr", 64'(we_gpr), 4'b1111);
        chk("alu4_we_fpr", 64'(we_fpr), 0);
        chk("alu4_waddr2", 64'(waddr[2]), 3);
        chk("alu4_wdata3", wdata[3], 64'h1003);
        rd_fpr = 4'b0100;
        #1;
        chk("fpr_we_gpr", 64'(we_gpr), 4'b1011);
        chk("fpr_we_fpr", 64'(we_fpr), 4'b0100);
        step();

        // Store behind port 0 blocks the tail.
        clr(); put(0, ALU); put(1, STORE); put(2, ALU); put(3, ALU);
        #2 chk("st_p1_ack", 64'(ack), 4'b0001);
        chk("st_p1_lsu", 64'(lsu), 0);
        step();
        clr(); put(0, STORE); put(1, ALU);
        #2 chk("st_nordy_ack", 64'(ack), 0);
        chk("st_nordy_lsu", 64'(lsu), 1);
        lsu_ready = 1;
        #1 chk("st_rdy_ack", 64'(ack), 4'b0011);
        step();

        // Exceptions, halt, single step, CSR.
        clr(); put(0, ALU); put(1, ALU); put(2, ALU); put(3, ALU);
        ex[1].valid = 1; ex[1].cause = 64'd7;
        #2 chk("ex_p1_ack", 64'(ack), 4'b0001);
        chk("ex_p1_exc", 64'(exc.valid), 0);
        ex[1] = '0; ex[0].valid = 1; ex[0].cause = 64'd13; ex[0].tval = 64'hABC;
        #1 chk("ex_p0_ack", 64'(ack), 0);
        chk("ex_p0_valid", 64'(exc.valid), 1);
        chk("ex_p0_cause", exc.cause, 13);
        chk("ex_p0_tval", exc.tval, 64'hABC);
        halt = 1;
        #1 chk("halt_exc", 64'(exc.valid), 0);
        ex[0] = '0;
        #1 chk("halt_ack", 64'(ack), 0);
        halt = 0; ss = 1;
        #1 chk("sstep_ack", 64'(ack), 4'b0001);
        ss = 0; cls[0] = OTHER;
        #1 chk("csr_ack", 64'(ack), 0);
        tid = 3'd5;
        #1 chk("tid", 64'(ctid), 5);
        step();

        // FP flag merge; non-FPU cause bits are ignored.
        clr(); put(0, FPU); put(1, FPU); put(2, ALU);
        ex[0].cause = 64'h04; ex[1].cause = 64'h01; ex[2].cause = 64'h10;
        #2 chk("ff_ack", 64'(ack), 4'b0111);
        chk("ff_flags", 64'(fflags), 5'h05);
        chk("ff_we", 64'(fflags_we), 1);
        step();

        // Fence with a busy store buffer for 5 cycles.
        clr(); nsp = 0; put(0, FENCE); put(1, ALU); put(2, ALU); put(3, ALU);
        #2 chk("fence_c0_ack", 64'(ack), 0);
        step();
        for (int c = 1; c <= 5; c++) begin
            #2 chk("fence_drain_ack", 64'(ack), 0);
            chk("fence_drain_pulse", 64'(fence), 0);
            step();
        end
        nsp = 1;
        #2 chk("fence_c6_ack", 64'(ack), 0);
        step();
        #2 chk("fence_issue_ack", 64'(ack), 4'b0001);
        chk("fence_issue_pulse", 64'(fence), 1);
        chk("fence_other_pulses", 64'({fence_i, sfence}), 0);
        step();
        valid = '0;
        #2 chk("fence_pulse_end", 64'(fence), 0);
        step();

        // fence.i with an empty store buffer: ISSUE on the second cycle.
        clr(); put(0, FENCE_I);
        #2 chk("fi_c0_ack", 64'(ack), 0);
        step();
        #2 chk("fi_c1_ack", 64'(ack), 0);
        chk("fi_c1_pulse", 64'(fence_i), 0);
        step();
        #2 chk("fi_c2_ack", 64'(ack), 4'b0001);
        chk("fi_c2_pulse", 64'(fence_i), 1);
        valid = '0;
        step();

        // sfence.vma with flush arriving in ISSUE: ISSUE still completes.
        clr(); put(0, SFENCE);
        step(); step();
        flush = 1;
        #2 chk("sf_flush_pulse", 64'(sfence), 1);
        chk("sf_flush_ack", 64'(ack), 4'b0001);
        valid = '0; flush = 0;
        step();

        // halt in DRAIN returns to IDLE; the fence restarts from scratch.
        clr(); nsp = 0; put(0, FENCE);
        step();
        halt = 1;
        #2 chk("hd_ack", 64'(ack), 0);
        step();
        halt = 0; nsp = 1;
        #2 chk("hd_idle_pulse", 64'(fence), 0);
        step();
        #2 chk("hd_no_pulse", 64'(fence), 0);
        step();
        #2 chk("hd_restart_pulse", 64'(fence), 1);
        valid = '0;
        step();

        // AMO: amo_ack at cycle 7, halt/flush ignored meanwhile.
        clr(); put(0, AMO); amo_res = 64'hDEAD_BEEF_0123_4567;
        #2 chk("amo_c0_valid", 64'(amo_valid), 0);
        step();
        for (int c = 1; c <= 6; c++) begin
            halt  = (c == 3);
            flush = (c == 4);
            #2 chk("amo_wait_valid", 64'(amo_valid), 1);
            chk("amo_wait_ack", 64'(ack), 0);
            step();
        end
        halt = 0; flush = 0; amo_ack = 1;
        #2 chk("amo_ack", 64'(ack), 4'b0001);
        chk("amo_flush_commit", 64'(flush_commit), 1);
        chk("amo_wdata", wdata[0], 64'hDEAD_BEEF_0123_4567);
        chk("amo_we_gpr", 64'(we_gpr), 4'b0001);
        step();
        amo_ack = 0; valid = '0;
        #2 chk("amo_done_valid", 64'(amo_valid), 0);
        chk("amo_done_flush", 64'(flush_commit), 0);
        step();

        // Reset while in AMO_WAIT.
        clr(); put(0, AMO);
        step();
        #2 chk("amorst_wait", 64'(amo_valid), 1);
        rst = 1;
        step();
        #2 chk("amorst_idle", 64'(amo_valid), 0);
        valid = '0;
        rst = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
